// File: rtl/tone_player_pkg.sv
// Shared types and defaults for the tone player: FSM state encoding,
// tick-counter width, default half-periods and the pitch-to-half-period lookup.
package tone_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int TICK_W     = 8;
  localparam int HALF_W_DEF = 20;

  // Half-periods in clk cycles at 50 MHz for C4, D4, E4, G4
  localparam int unsigned HALF_P0_DEF = 32'd95420;
  localparam int unsigned HALF_P1_DEF = 32'd85034;
  localparam int unsigned HALF_P2_DEF = 32'd75758;
  localparam int unsigned HALF_P3_DEF = 32'd63776;

  // Select the half-period belonging to a 2-bit pitch code
  function automatic logic [31:0] pick_half(input logic [1:0] pitch,
                                            input logic [31:0] h0,
                                            input logic [31:0] h1,
                                            input logic [31:0] h2,
                                            input logic [31:0] h3);
    logic [31:0] res_s;
    case (pitch)
      2'd0:    res_s = h0;
      2'd1:    res_s = h1;
      2'd2:    res_s = h2;
      2'd3:    res_s = h3;
      default: res_s = h0;
    endcase
    return res_s;
  endfunction

endpackage

// File: rtl/tone_player_osc.sv
// Square-wave oscillator: a half-period down-counter that reloads at 1 and
// toggles the phase. Exposes the next phase so the parent can register a
// gated audio output that lines up with its own state register.
module tone_osc
  import tone_player_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              enable,
  input  logic [HALF_W-1:0] half_period,
  output logic              phase_next
);

  localparam logic [HALF_W-1:0] CNT_ONE = HALF_W'(1);

  logic [HALF_W-1:0] cnt_r;
  logic [HALF_W-1:0] cnt_nxt_s;
  logic              phase_r;
  logic              phase_nxt_s;

  // Next counter/phase: load starts high, count down while enabled, clear otherwise
  always_comb begin
    cnt_nxt_s   = cnt_r;
    phase_nxt_s = phase_r;
    if (load) begin
      cnt_nxt_s   = half_period;
      phase_nxt_s = 1'b1;
    end else if (enable) begin
      if (cnt_r == CNT_ONE) begin
        cnt_nxt_s   = half_period;
        phase_nxt_s = ~phase_r;
      end else begin
        cnt_nxt_s = cnt_r - CNT_ONE;
      end
    end else begin
      cnt_nxt_s   = {HALF_W{1'b0}};
      phase_nxt_s = 1'b0;
    end
  end

  // Oscillator state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= {HALF_W{1'b0}};
      phase_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      phase_r <= phase_nxt_s;
    end
  end

  assign phase_next = phase_nxt_s;

endmodule

// File: rtl/tone_player.sv
// Plays one note at a time: square wave at the latched pitch for a number of
// 60 Hz ticks, followed by a fixed silent gap, then reports completion.
module tone_player
  import tone_player_pkg::*;
#(
  parameter int unsigned HALF_P0   = HALF_P0_DEF,
  parameter int unsigned HALF_P1   = HALF_P1_DEF,
  parameter int unsigned HALF_P2   = HALF_P2_DEF,
  parameter int unsigned HALF_P3   = HALF_P3_DEF,
  parameter int          HALF_W    = HALF_W_DEF,
  parameter int unsigned GAP_TICKS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_60hz,
  input  logic              stop,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [1:0]        note_pitch,
  input  logic              note_volume,
  input  logic [TICK_W-1:0] note_ticks,
  output logic              audio_out,
  output logic [1:0]        cur_pitch,
  output logic              cur_volume,
  output logic              busy,
  output logic              done
);

  localparam logic [TICK_W-1:0] GAP_CNT  = TICK_W'(GAP_TICKS);
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);

  state_t            state_r, state_nxt_s;
  logic [TICK_W-1:0] tick_cnt_r, tick_cnt_nxt_s;
  logic [1:0]        pitch_r, pitch_nxt_s;
  logic              vol_r, vol_nxt_s;
  logic              done_r, done_nxt_s;
  logic              audio_r, ready_r, busy_r;
  logic              load_s;
  logic [HALF_W-1:0] half_s;
  logic              phase_nxt_s;

  // Next state, tick counter, latched note and completion pulse
  always_comb begin
    state_nxt_s    = state_r;
    tick_cnt_nxt_s = tick_cnt_r;
    pitch_nxt_s    = pitch_r;
    vol_nxt_s      = vol_r;
    done_nxt_s     = 1'b0;
    load_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (note_valid && !stop) begin
          if (note_ticks != {TICK_W{1'b0}}) begin
            state_nxt_s    = ST_PLAY;
            tick_cnt_nxt_s = note_ticks;
            pitch_nxt_s    = note_pitch;
            vol_nxt_s      = note_volume;
            load_s         = 1'b1;
          end else begin
            done_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          state_nxt_s    = ST_IDLE;
          tick_cnt_nxt_s = {TICK_W{1'b0}};
          pitch_nxt_s    = 2'd0;
          vol_nxt_s      = 1'b0;
        end else if (tick_60hz) begin
          if (tick_cnt_r == TICK_ONE) begin
            if (GAP_TICKS != 0) begin
              state_nxt_s    = ST_GAP;
              tick_cnt_nxt_s = GAP_CNT;
            end else begin
              state_nxt_s    = ST_IDLE;
              tick_cnt_nxt_s = {TICK_W{1'b0}};
              pitch_nxt_s    = 2'd0;
              vol_nxt_s      = 1'b0;
              done_nxt_s     = 1'b1;
            end
          end else begin
            tick_cnt_nxt_s = tick_cnt_r - TICK_ONE;
          end
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      ST_GAP: begin
        if (stop) begin
          state_nxt_s    = ST_IDLE;
          tick_cnt_nxt_s = {TICK_W{1'b0}};
          pitch_nxt_s    = 2'd0;
          vol_nxt_s      = 1'b0;
        end else if (tick_60hz) begin
          if (tick_cnt_r == TICK_ONE) begin
            state_nxt_s    = ST_IDLE;
            tick_cnt_nxt_s = {TICK_W{1'b0}};
            pitch_nxt_s    = 2'd0;
            vol_nxt_s      = 1'b0;
            done_nxt_s     = 1'b1;
          end else begin
            tick_cnt_nxt_s = tick_cnt_r - TICK_ONE;
          end
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        tick_cnt_nxt_s = {TICK_W{1'b0}};
        pitch_nxt_s    = 2'd0;
        vol_nxt_s      = 1'b0;
      end
    endcase
  end

  // Half-period for the oscillator: incoming pitch on load, latched pitch otherwise
  always_comb begin
    if (load_s) begin
      half_s = HALF_W'(pick_half(note_pitch, HALF_P0, HALF_P1, HALF_P2, HALF_P3));
    end else begin
      half_s = HALF_W'(pick_half(pitch_r, HALF_P0, HALF_P1, HALF_P2, HALF_P3));
    end
  end

  tone_osc #(.HALF_W(HALF_W)) u_osc (
    .clk        (clk),
    .reset      (reset),
    .load       (load_s),
    .enable     (state_r == ST_PLAY),
    .half_period(half_s),
    .phase_next (phase_nxt_s)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= {TICK_W{1'b0}};
      pitch_r    <= 2'd0;
      vol_r      <= 1'b0;
      done_r     <= 1'b0;
      audio_r    <= 1'b0;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tick_cnt_r <= tick_cnt_nxt_s;
      pitch_r    <= pitch_nxt_s;
      vol_r      <= vol_nxt_s;
      done_r     <= done_nxt_s;
      audio_r    <= phase_nxt_s & vol_nxt_s & (state_nxt_s == ST_PLAY);
      ready_r    <= (state_nxt_s == ST_IDLE);
      busy_r     <= (state_nxt_s != ST_IDLE);
    end
  end

  assign note_ready = ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign audio_out  = audio_r;
  assign cur_pitch  = pitch_r;
  assign cur_volume = vol_r;

endmodule

// File: tb/tb_tone_player.sv
// Self-checking bench for tone_player. The reference model predicts each
// note's timeline (play end / gap end edges) from the fixed tick schedule and
// derives audio from elapsed cycles; outputs are compared every cycle.
module tb_tone_player;

  localparam int GAP  = 2;
  localparam int TPER = 50;
  localparam int TOFF = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_60hz = 1'b0;
  logic       stop = 1'b0;
  logic       note_valid = 1'b0;
  logic       note_ready;
  logic [1:0] note_pitch = 2'd0;
  logic       note_volume = 1'b0;
  logic [7:0] note_ticks = 8'd0;
  logic       audio_out;
  logic [1:0] cur_pitch;
  logic       cur_volume;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  tone_player #(
    .HALF_P0(4), .HALF_P1(5), .HALF_P2(6), .HALF_P3(7),
    .HALF_W(20), .GAP_TICKS(GAP)
  ) dut (
    .clk(clk), .reset(reset), .tick_60hz(tick_60hz), .stop(stop),
    .note_valid(note_valid), .note_ready(note_ready), .note_pitch(note_pitch),
    .note_volume(note_volume), .note_ticks(note_ticks), .audio_out(audio_out),
    .cur_pitch(cur_pitch), .cur_volume(cur_volume), .busy(busy), .done(done)
  );

  int n_vec = 0;
  int n_err = 0;
  int e = 0;

  // Reference model: timeline of the note in flight, in step-edge numbers
  bit m_act = 1'b0;
  int m_a = 0;
  int m_pend = 0;
  int m_gend = 0;
  int m_zd = -1;
  int m_pitch = 0;
  int m_vol = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, e);
    end
  endtask

  // 0 = idle, 1 = playing, 2 = gap, at the current edge count
  function automatic int m_state();
    if (!m_act) return 0;
    if (e < m_pend) return 1;
    if (e < m_gend) return 2;
    return 0;
  endfunction

  task automatic compare_all();
    int st;
    int h;
    bit exp_audio;
    bit exp_done;
    st = m_state();
    h = 4 + m_pitch;
    exp_audio = (st == 1) && (m_vol != 0) && ((((e - m_a) / h) % 2) == 0);
    exp_done = (m_act && (e == m_gend)) || (e == m_zd);
    check("note_ready", 32'(note_ready), 32'(st == 0));
    check("busy",       32'(busy),       32'(st != 0));
    check("done",       32'(done),       32'(exp_done));
    check("audio_out",  32'(audio_out),  32'(exp_audio));
    check("cur_pitch",  32'(cur_pitch),  (st != 0) ? 32'(m_pitch) : 32'd0);
    check("cur_volume", 32'(cur_volume), (st != 0) ? 32'(m_vol) : 32'd0);
  endtask

  // Apply one cycle of inputs, advance the model, clock, then compare
  task automatic step(input logic v, input logic [1:0] p, input logic vol,
                      input logic [7:0] t, input logic s);
    int t1;
    if (m_act && (e >= m_gend)) m_act = 1'b0;
    note_valid  = v;
    note_pitch  = p;
    note_volume = vol;
    note_ticks  = t;
    stop        = s;
    tick_60hz   = (((e + 1) % TPER) == TOFF);
    if (!m_act) begin
      if (v && !s) begin
        if (t != 8'd0) begin
          m_act   = 1'b1;
          m_a     = e + 1;
          t1      = m_a + 1 + ((TOFF - ((m_a + 1) % TPER) + TPER) % TPER);
          m_pend  = t1 + TPER * (int'(t) - 1);
          m_gend  = m_pend + TPER * GAP;
          m_pitch = int'(p);
          m_vol   = int'(vol);
        end else begin
          m_zd = e + 1;
        end
      end
    end else if (s) begin
      m_act = 1'b0;
    end
    @(posedge clk);
    e++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'd0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic send(input logic [1:0] p, input logic vol, input logic [7:0] t);
    step(1'b1, p, vol, t, 1'b0);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while ((done !== 1'b1) && (n < bound)) begin
      idle(1);
      n++;
    end
    check("done_reached", 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int dn;
    #1 reset = 1'b1;
    #1;
    check("rst_audio", 32'(audio_out),  32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_done",  32'(done),       32'd0);
    check("rst_pitch", 32'(cur_pitch),  32'd0);
    check("rst_vol",   32'(cur_volume), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready", 32'(note_ready), 32'd1);

    // 1: audible pitch 1, three ticks
    idle(3);
    send(2'd1, 1'b1, 8'd3);
    check("s1_busy",  32'(busy),      32'd1);
    check("s1_aud_h", 32'(audio_out), 32'd1);
    check("s1_pitch", 32'(cur_pitch), 32'd1);
    idle(5);
    check("s1_aud_l", 32'(audio_out), 32'd0);
    idle(5);
    check("s1_aud_h2", 32'(audio_out), 32'd1);
    wait_done(1000);
    check("s1_ready_on_done", 32'(note_ready), 32'd1);
    dn = 0;
    repeat (60) begin
      idle(1);
      if (done === 1'b1) dn++;
    end
    check("s1_single_done", 32'(dn), 32'd0);

    // 2: muted two-tick note
    send(2'd2, 1'b0, 8'd2);
    check("s2_vol",   32'(cur_volume), 32'd0);
    check("s2_pitch", 32'(cur_pitch),  32'd2);
    check("s2_busy",  32'(busy),       32'd1);
    wait_done(1000);
    idle(3);

    // 3: zero-length note
    send(2'd3, 1'b1, 8'd0);
    check("s3_done",  32'(done), 32'd1);
    check("s3_busy",  32'(busy), 32'd0);
    idle(1);
    check("s3_done_once", 32'(done), 32'd0);

    // 4: back-to-back, second offered on the done cycle
    send(2'd0, 1'b1, 8'd1);
    idle(4);
    check("s4_p0_lo", 32'(audio_out), 32'd0);
    wait_done(1000);
    send(2'd3, 1'b1, 8'd1);
    check("s4_busy",  32'(busy),      32'd1);
    check("s4_pitch", 32'(cur_pitch), 32'd3);
    idle(7);
    check("s4_p3_lo", 32'(audio_out), 32'd0);
    wait_done(1000);

    // 5: stop mid-play, then a stop-coincident offer in idle
    send(2'd1, 1'b1, 8'd3);
    idle(60);
    step(1'b0, 2'd0, 1'b0, 8'd0, 1'b1);
    check("s5_busy",  32'(busy),       32'd0);
    check("s5_audio", 32'(audio_out),  32'd0);
    check("s5_done",  32'(done),       32'd0);
    check("s5_ready", 32'(note_ready), 32'd1);
    dn = 0;
    repeat (200) begin
      idle(1);
      if (done === 1'b1) dn++;
    end
    check("s5_no_done", 32'(dn), 32'd0);
    step(1'b1, 2'd1, 1'b1, 8'd2, 1'b1);
    check("s5_stop_blocks", 32'(busy), 32'd0);
    send(2'd2, 1'b1, 8'd1);
    check("s5_busy2", 32'(busy), 32'd1);
    wait_done(1000);

    // 6: asynchronous reset mid-play
    send(2'd0, 1'b1, 8'd4);
    idle(20);
    #2 reset = 1'b1;
    #1;
    check("s6_audio", 32'(audio_out),  32'd0);
    check("s6_busy",  32'(busy),       32'd0);
    check("s6_pitch", 32'(cur_pitch),  32'd0);
    check("s6_vol",   32'(cur_volume), 32'd0);
    check("s6_done",  32'(done),       32'd0);
    tick_60hz  = 1'b0;
    note_valid = 1'b0;
    m_act = 1'b0;
    m_zd  = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("s6_ready", 32'(note_ready), 32'd1);
    idle(3);
    send(2'd1, 1'b1, 8'd1);
    wait_done(1000);

    // Randomized traffic
    repeat (6000) begin
      int r;
      logic [7:0] t;
      r = int'($urandom_range(0, 9));
      if (r < 2) t = 8'd0;
      else t = 8'($urandom_range(1, 4));
      step(1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tone_player.md
Name: tone_player

Overview:
Downstream consumer of the 60 Hz rate-divider tick. Accepts one note (2-bit pitch, 1-bit volume, duration in 60 Hz ticks) over a valid/ready handshake. Plays the note as a square wave at the selected pitch for that many ticks, then holds an inter-note silence before accepting the next note. Also drives the latched pitch/volume to the LED display path.

Parameters:
HALF_P0, 95420, half-period in clk cycles for pitch 0 (262 Hz at 50 MHz)
HALF_P1, 85034, half-period for pitch 1 (294 Hz)
HALF_P2, 75758, half-period for pitch 2 (330 Hz)
HALF_P3, 63776, half-period for pitch 3 (392 Hz)
HALF_W, 20, width of half-period counter
GAP_TICKS, 3, silent ticks after each note (0 = no gap)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
tick_60hz  in  1  one-clk-wide pulse from rate divider
stop  in  1  synchronous abort, active-high
note_valid  in  1  upstream has a note
note_ready  out  1  block can accept a note
note_pitch  in  2  pitch select
note_volume  in  1  1 = audible, 0 = muted (timed rest)
note_ticks  in  8  duration in ticks
audio_out  out  1  square-wave output
cur_pitch  out  2  latched pitch (to LED display)
cur_volume  out  1  latched volume (to LED display)
busy  out  1  high in PLAY or GAP
done  out  1  one-cycle pulse on note completion

Behaviour:
- Reset (async, any state): state=IDLE; audio_out=0, cur_pitch=0, cur_volume=0, busy=0, done=0; all counters 0. note_ready=1 once reset deasserts.
- States: IDLE, PLAY, GAP. note_ready = (state==IDLE). busy = (state!=IDLE).
- IDLE: on note_valid & note_ready, latch pitch/volume/ticks.
  - note_ticks!=0: go to PLAY next cycle. Tick counter = note_ticks. Half-period counter = HALF_Px of the latched pitch. Phase=1.
  - note_ticks==0: the note is accepted but not played. State stays IDLE. done pulses next cycle. Outputs are unchanged.
- A tick_60hz coincident with the accept cycle is not counted.
- PLAY:
  - Half-period counter decrements each clk. At 1, it reloads HALF_Px and toggles phase. Period = 2*HALF_Px clk exactly.
  - Each tick_60hz decrements the tick counter. A tick arriving when the counter = 1 ends PLAY.
  - On end of PLAY: if GAP_TICKS>0, go to GAP with the counter loaded with GAP_TICKS. Otherwise go to IDLE and pulse done.
- GAP: audio silent. Each tick decrements the counter. A tick at count 1 goes to IDLE and pulses done.
- audio_out (registered) = phase & cur_volume & (state==PLAY). Goes high the cycle after accept when volume=1. Muted notes time identically with audio_out=0.
- cur_pitch/cur_volume hold the latched values in PLAY and GAP. Both are 0 in IDLE.
- done is registered and coincides with the first IDLE cycle. Upstream may present the next note in that cycle, so back-to-back notes are allowed.
- stop: from PLAY or GAP, go to IDLE next cycle. audio_out=0, no done pulse. Ignored in IDLE; a note offered in the same cycle as stop is not accepted.
- stop and final tick in the same cycle: stop wins, no done.
- Counter arithmetic is unsigned. No wrap is possible because counters reload before reaching 0.

Decomposition:
- Shared package: state encoding constants (IDLE/PLAY/GAP), TICK_W=8, default HALF_Px values.
- One natural sub-module: tone_osc (half-period counter + phase toggle, parameterised by HALF_W, with load/enable inputs).
- The FSM and tick counter stay in tone_player.

Test Plan:
Bench parameters for all scenarios: HALF_P0..3=4,5,6,7; GAP_TICKS=2; tick_60hz pulsed every 50 clk.
1. Note pitch=1, vol=1, ticks=3 -> audio_out toggles every 5 clk during PLAY. PLAY ends on the 3rd tick. GAP lasts 2 ticks. done pulses exactly once. note_ready returns high on the done cycle.
2. vol=0, ticks=2 -> audio_out stays 0 throughout. busy and done timing identical to an audible 2-tick note. cur_volume=0, cur_pitch latched.
3. ticks=0 -> accepted in one cycle, done pulses next cycle. busy never asserts, audio_out stays 0.
4. Two notes back-to-back, with the second offered on the done cycle -> second accepted that cycle. No idle gap beyond GAP_TICKS. Pitch changes from 4-clk to 7-clk half-period.
5. stop asserted mid-PLAY after the 1st tick -> IDLE next cycle, audio_out=0, no done. A new note is then accepted normally.
6. reset asserted asynchronously mid-PLAY (between clk edges) -> all outputs 0 immediately. note_ready=1 after release.
